umidade_sensor_rx: RTL and testbench
====================================

// Module: umidade_sensor_rx
// PURPOSE
//  Acquisition end of the soil-humidity alarm path. Takes the two raw sensor
//  lines (board switches / sensor pins) and synchronizes and debounces them.
//  Outputs the stable 2-bit humidity state for the 7-segment alarm encoder in
//  top. Each state change is also issued as an event on a valid/ready
//  handshake, and transitions into a dry condition are counted.
// PARAMETERS
//  DEBOUNCE  4  consecutive synchronized cycles a new level must hold (>=2)
//  CNT_W     8  width of the dry-transition counter
// PORTS
//  clk_2      in   1      system clock (the only clock)
//  reset_n    in   1      synchronous, active-low reset
//  sens_raw   in   2      raw sensor lines; bit0 = sensor 0, bit1 = sensor 1; 1 = low humidity
//  estado     out  2      debounced stable state, same bit mapping as sens_raw
//  evt_valid  out  1      event pending
//  evt_code   out  2      new state carried by the pending event
//  evt_ready  in   1      consumer accepts the event
//  overrun    out  1      sticky: a pending event was overwritten before acceptance
//  dry_count  out  CNT_W  number of 00 -> nonzero transitions, saturating
//  seg        out  8      7-segment pattern of estado (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk_2 rising edge) clears all of the following on that edge:
//    - synchronizer flops, debounce counters, estado=00, evt_valid=0, evt_code=00,
//      overrun=0, dry_count=0.
//    - seg follows estado, so seg=8'h00 while in reset.
//    - Reset mid-debounce or mid-handshake discards the partial count and the pending event.
//  - Synchronizer: 2 flops per channel; s[i] is the second-stage output.
//  - Debounce, independently per channel, with a counter of clog2(DEBOUNCE) bits:
//    - s[i]==estado[i]: counter cleared to 0.
//    - s[i]!=estado[i] and cnt<DEBOUNCE-1: cnt increments.
//    - s[i]!=estado[i] and cnt==DEBOUNCE-1: estado[i]<=s[i] and cnt<=0.
//    - Latency: a clean raw change appears on estado exactly DEBOUNCE+2 edges later.
//      With the default, a change sampled at edge 1 updates estado at edge 6.
//    - A glitch that is stable for fewer than DEBOUNCE synchronized cycles never
//      reaches estado.
//  - Event generation (chg = next estado != estado):
//    - Both channels changing on the same edge produce one event carrying both bits.
//    - On the edge where estado updates, evt_code<=new estado and evt_valid<=1.
//    - Transfer occurs on an edge where evt_valid&&evt_ready. Without a chg on that
//      edge, evt_valid<=0. With a chg on that edge, evt_valid stays 1 with the new
//      code and no overrun is flagged.
//    - chg while evt_valid&&!evt_ready: evt_code is overwritten, evt_valid stays 1,
//      overrun<=1. overrun is cleared only by reset.
//    - evt_code is held stable while evt_valid=1 and no new chg occurs.
//  - dry_count: increments on an edge where estado goes from 00 to nonzero.
//    It holds at 2**CNT_W-1 and never wraps.
//  - All outputs are registered, except seg, which is combinational from estado.
// CONFIGURATION
//  UMIDADE_SEG_EN defined: seg decodes estado as follows.
//    00 -> 8'h00
//    01 -> 8'h3F
//    10 -> 8'h06
//    11 -> 8'h5B
//  UMIDADE_SEG_EN undefined: seg is tied to 8'h00 and the decoder is not built.
//    The port list is identical in both builds.
// TESTING
//  1. reset_n=0 for 2 edges with sens_raw=11, then release.
//     -> all outputs 0 during reset; estado=11 and evt_valid=1 with evt_code=11
//        on edge 6 after release; dry_count=1.
//  2. sens_raw 00->01, evt_ready=1 -> estado=01 at edge 6 after the change;
//     evt_valid high for exactly 1 cycle; seg=8'h3F (macro on) / 8'h00 (off).
//  3. sens_raw=10 pulse lasting 3 cycles, DEBOUNCE=4 -> estado stays 00; no event;
//     dry_count unchanged.
//  4. evt_ready=0; raw 00->01, then 01->11 after 10 cycles.
//     -> evt_code goes 01 then 11; overrun=1; evt_valid stays 1 until evt_ready=1.
//  5. Toggle raw 00<->10 with a period >2*(DEBOUNCE+2), 300 times.
//     -> dry_count saturates at 255 with no wrap.
//  6. Drive reset_n=0 for 1 edge at debounce cnt=2 with an event pending.
//     -> evt_valid=0, estado=00, overrun=0; the previous change is lost and
//        re-debounced from scratch.

Source files
------------

// File: rtl/umidade_sensor_rx.sv
// Soil-humidity sensor receiver: synchronizes and debounces two raw sensor lines,
// issues state-change events on a valid/ready handshake, and counts dry transitions.
// Optional macro UMIDADE_SEG_EN builds the 7-segment decoder on seg; otherwise seg is 8'h00.
module umidade_sensor_rx #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [1:0]       sens_raw,
    output logic [1:0]       estado,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    input  logic             evt_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] dry_count,
    output logic [7:0]       seg
);

    localparam int unsigned NCH  = 2;
    localparam int unsigned DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] DRY_MAX = {CNT_W{1'b1}};

    logic [NCH-1:0]  sync1_q;
    logic [NCH-1:0]  sync2_q;
    logic [DB_W-1:0] db_cnt_q [NCH];
    logic [DB_W-1:0] db_cnt_d [NCH];
    logic [NCH-1:0]  estado_d;
    logic            chg;
    logic            dry_edge;

    // Two-flop synchronizer per channel
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sens_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: a differing level must persist DEBOUNCE cycles
    always_comb begin
        estado_d = estado;
        for (int i = 0; i < NCH; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != estado[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    estado_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= '0;
            end
            estado <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            estado <= estado_d;
        end
    end

    assign chg      = (estado_d != estado);
    assign dry_edge = (estado == '0) && (estado_d != '0);

    // Event handshake; a new change always wins over a same-cycle acceptance
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (chg) begin
                evt_valid <= 1'b1;
                evt_code  <= estado_d;
                if (evt_valid && !evt_ready) begin
                    overrun <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

    // Saturating count of entries into a dry condition
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            dry_count <= '0;
        end else if (dry_edge && (dry_count != DRY_MAX)) begin
            dry_count <= dry_count + CNT_W'(1);
        end
    end

`ifdef UMIDADE_SEG_EN
    always_comb begin
        seg = 8'h00;
        case (estado)
            2'b01:   seg = 8'h3F;
            2'b10:   seg = 8'h06;
            2'b11:   seg = 8'h5B;
            default: seg = 8'h00;
        endcase
    end
`else
    assign seg = 8'h00;
`endif

endmodule

// File: tb/tb_umidade_sensor_rx.sv
// Randomized bench for umidade_sensor_rx against a window-based behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_umidade_sensor_rx;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned CNT_W    = 8;
`ifdef UMIDADE_SEG_EN
    localparam logic [7:0] SEG01 = 8'h3F;
`else
    localparam logic [7:0] SEG01 = 8'h00;
`endif

    logic             clk_2;
    logic             reset_n;
    logic [1:0]       sens_raw;
    logic [1:0]       estado;
    logic             evt_valid;
    logic [1:0]       evt_code;
    logic             evt_ready;
    logic             overrun;
    logic [CNT_W-1:0] dry_count;
    logic [7:0]       seg;

    int checks = 0;
    int errors = 0;

    umidade_sensor_rx #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
        .clk_2    (clk_2),
        .reset_n  (reset_n),
        .sens_raw (sens_raw),
        .estado   (estado),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .overrun  (overrun),
        .dry_count(dry_count),
        .seg      (seg)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [1:0] e);
`ifdef UMIDADE_SEG_EN
        case (e)
            2'b01:   return 8'h3F;
            2'b10:   return 8'h06;
            2'b11:   return 8'h5B;
            default: return 8'h00;
        endcase
`else
        return 8'h00 & {8{e[0]}};
`endif
    endfunction

    // Behavioural model: raw delayed two edges, level accepted once the last
    // DEBOUNCE synchronized samples all disagree with the current state.
    logic [1:0] m_pipe0, m_pipe1, m_est, m_new, m_code, m_s;
    logic       m_valid, m_ovr, m_live, m_all;
    int         m_dry;
    logic [1:0] m_hist[$];

    initial m_live = 1'b0;

    always @(posedge clk_2) begin
        if (!reset_n) begin
            m_pipe0 = 2'b00; m_pipe1 = 2'b00; m_est = 2'b00; m_code = 2'b00;
            m_valid = 1'b0;  m_ovr = 1'b0;    m_dry = 0;
            m_hist.delete();
            m_live = 1'b1;
        end else if (m_live) begin
            m_s = m_pipe1;
            m_hist.push_back(m_s);
            if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
            m_new = m_est;
            if (m_hist.size() == DEBOUNCE) begin
                for (int b = 0; b < 2; b++) begin
                    m_all = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][b] == m_est[b]) m_all = 1'b0;
                    if (m_all) m_new[b] = ~m_est[b];
                end
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = sens_raw;
            if (m_new != m_est) begin
                if (m_valid && !evt_ready) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_code  = m_new;
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
            if (m_est == 2'b00 && m_new != 2'b00 && m_dry < 255) m_dry++;
            m_est = m_new;
        end
    end

    // Compare process: every cycle once the model is initialised
    always @(negedge clk_2) begin
        if (m_live) begin
            check("estado",    32'(estado),    32'(m_est));
            check("evt_valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) check("evt_code", 32'(evt_code), 32'(m_code));
            check("overrun",   32'(overrun),   32'(m_ovr));
            check("dry_count", 32'(dry_count), 32'(m_dry));
            check("seg",       32'(seg),       32'(exp_seg(m_est)));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    initial begin
        // T1: reset with 11 held
        reset_n = 1'b0; sens_raw = 2'b11; evt_ready = 1'b1;
        tick(2);
        check("t1_rst_estado", 32'(estado), 0);
        check("t1_rst_valid",  32'(evt_valid), 0);
        check("t1_rst_code",   32'(evt_code), 0);
        check("t1_rst_ovr",    32'(overrun), 0);
        check("t1_rst_dry",    32'(dry_count), 0);
        check("t1_rst_seg",    32'(seg), 0);
        reset_n = 1'b1;
        tick(5);
        check("t1_est_e5", 32'(estado), 0);
        tick(1);
        check("t1_est_e6",  32'(estado), 32'h3);
        check("t1_valid",   32'(evt_valid), 1);
        check("t1_code",    32'(evt_code), 32'h3);
        check("t1_dry",     32'(dry_count), 1);
        sens_raw = 2'b00;
        tick(8);

        // T2: 00 -> 01 with ready
        sens_raw = 2'b01;
        tick(5);
        check("t2_est_e5", 32'(estado), 0);
        tick(1);
        check("t2_est_e6", 32'(estado), 1);
        check("t2_valid",  32'(evt_valid), 1);
        check("t2_seg",    32'(seg), 32'(SEG01));
        tick(1);
        check("t2_valid_1cyc", 32'(evt_valid), 0);
        check("t2_dry",        32'(dry_count), 2);
        sens_raw = 2'b00;
        tick(8);

        // T3: 3-cycle glitch
        sens_raw = 2'b10;
        tick(3);
        sens_raw = 2'b00;
        tick(10);
        check("t3_est",   32'(estado), 0);
        check("t3_valid", 32'(evt_valid), 0);
        check("t3_dry",   32'(dry_count), 2);

        // T4: overwrite of a pending event
        evt_ready = 1'b0; sens_raw = 2'b01;
        tick(10);
        check("t4_code1", 32'(evt_code), 1);
        check("t4_ovr0",  32'(overrun), 0);
        check("t4_dry",   32'(dry_count), 3);
        sens_raw = 2'b11;
        tick(10);
        check("t4_code2", 32'(evt_code), 32'h3);
        check("t4_ovr1",  32'(overrun), 1);
        check("t4_valid", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        tick(1);
        check("t4_valid_done", 32'(evt_valid), 0);
        check("t4_ovr_sticky", 32'(overrun), 1);

        // T6: reset mid-debounce with an event pending
        sens_raw = 2'b00;
        tick(8);
        evt_ready = 1'b0; sens_raw = 2'b01;
        tick(8);
        sens_raw = 2'b11;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        check("t6_valid", 32'(evt_valid), 0);
        check("t6_est",   32'(estado), 0);
        check("t6_ovr",   32'(overrun), 0);
        check("t6_dry",   32'(dry_count), 0);
        reset_n = 1'b1;
        tick(5);
        check("t6_est_e5", 32'(estado), 0);
        tick(1);
        check("t6_est_e6", 32'(estado), 32'h3);
        check("t6_dry1",   32'(dry_count), 1);

        // T5: saturation of dry_count
        evt_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sens_raw = 2'b10; tick(14);
            sens_raw = 2'b00; tick(14);
        end
        check("t5_dry_sat",   32'(dry_count), 255);
        check("t5_model_dry", 32'(m_dry), 255);

        // Randomized phase
        for (int seg_i = 0; seg_i < 600; seg_i++) begin
            sens_raw  = 2'($urandom_range(0, 3));
            evt_ready = 1'($urandom_range(0, 1));
            reset_n   = ($urandom_range(0, 149) != 0);
            tick(1);
            reset_n = 1'b1;
            tick(int'($urandom_range(0, 9)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
